// File: rtl/iq_demux_pkg.sv
// iq_demux_pkg: mode encodings, I/Q levels, Gray mapping and counter-width helper
package iq_demux_pkg;
    localparam logic MODE_QPSK  = 1'b0;
    localparam logic MODE_16QAM = 1'b1;
    localparam logic signed [2:0] LVL_P3 = 3'sd3;
    localparam logic signed [2:0] LVL_P1 = 3'sd1;
    localparam logic signed [2:0] LVL_M1 = -3'sd1;
    localparam logic signed [2:0] LVL_M3 = -3'sd3;

    function automatic int cnt_w(input int n);
        return n > 2 ? $clog2(n) : 1;
    endfunction

    // bits = {msb, lsb} of one axis; QPSK looks only at the msb
    function automatic logic signed [2:0] gray_map(input logic [1:0] bits, input logic mode);
        if (mode == MODE_QPSK) return bits[1] ? LVL_P1 : LVL_M1;
        return bits[1] ? (bits[0] ? LVL_P1 : LVL_P3) : (bits[0] ? LVL_M1 : LVL_M3);
    endfunction
endpackage

// File: rtl/iq_bit_slicer.sv
// iq_bit_slicer: oversamples ser_i on a divided tick grid and decides each bit by majority
module iq_bit_slicer
    import iq_demux_pkg::*;
#(
    parameter int DIV_MAX = 100,
    parameter int OSR     = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic sync_clr,
    input  logic ser_i,
    output logic bit_val,
    output logic bit_stb
);
    localparam int DW = cnt_w(DIV_MAX);
    localparam int SW = cnt_w(OSR);
    localparam int AW = cnt_w(OSR + 1);

    logic [DW-1:0] cnt_div;
    logic [SW-1:0] cnt_samp;
    logic [AW-1:0] ones_acc;
    logic          tick, last;
    logic [AW:0]   total;

    assign tick  = en && !sync_clr && cnt_div == DW'(DIV_MAX - 1);
    assign last  = cnt_samp == SW'(OSR - 1);
    assign total = {1'b0, ones_acc} + (AW + 1)'(ser_i);
    // decision is combinational so the symbol lands on the final tick edge; ties resolve to 0
    assign bit_stb = tick && last;
    assign bit_val = {total, 1'b0} > (AW + 2)'(OSR);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt_div  <= '0;
            cnt_samp <= '0;
            ones_acc <= '0;
        end else if (sync_clr) begin
            cnt_div  <= '0;
            cnt_samp <= '0;
            ones_acc <= '0;
        end else if (en) begin
            cnt_div <= tick ? '0 : cnt_div + DW'(1);
            if (tick) begin
                cnt_samp <= last ? '0 : cnt_samp + SW'(1);
                ones_acc <= last ? '0 : ones_acc + AW'(ser_i);
            end
        end
endmodule

// File: rtl/iq_demux_mqam.sv
// iq_demux_mqam: groups majority-decided bits into QPSK/16-QAM symbols and emits Gray-mapped signed I/Q
module iq_demux_mqam
    import iq_demux_pkg::*;
#(
    parameter int DIV_MAX = 100,
    parameter int OSR     = 100,
    parameter int OUT_W   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    sync_clr,
    input  logic                    mode,
    input  logic                    ser_i,
    output logic signed [OUT_W-1:0] I,
    output logic signed [OUT_W-1:0] Q,
    output logic                    sym_valid,
    output logic                    mode_act
);
    logic       bit_val, bit_stb, last_bit;
    logic [1:0] bit_idx;
    logic [3:0] sym_reg, sym_nxt;

    iq_bit_slicer #(.DIV_MAX(DIV_MAX), .OSR(OSR)) u_slicer (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .sync_clr (sync_clr),
        .ser_i    (ser_i),
        .bit_val  (bit_val),
        .bit_stb  (bit_stb)
    );

    always_comb begin
        sym_nxt          = sym_reg;
        sym_nxt[bit_idx] = bit_val;
    end

    assign last_bit = bit_stb && bit_idx == (mode_act == MODE_16QAM ? 2'd3 : 2'd1);

    // even slots feed Q, odd slots feed I, first bit per axis is its msb
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            I         <= '1;
            Q         <= '1;
            sym_valid <= 1'b0;
            mode_act  <= MODE_QPSK;
            bit_idx   <= '0;
            sym_reg   <= '0;
        end else if (sync_clr) begin
            sym_valid <= 1'b0;
            mode_act  <= mode;
            bit_idx   <= '0;
            sym_reg   <= '0;
        end else begin
            sym_valid <= last_bit;
            if (bit_stb) begin
                sym_reg <= last_bit ? '0 : sym_nxt;
                bit_idx <= last_bit ? '0 : bit_idx + 2'd1;
            end
            if (last_bit) begin
                Q        <= OUT_W'(gray_map({sym_nxt[0], sym_nxt[2]}, mode_act));
                I        <= OUT_W'(gray_map({sym_nxt[1], sym_nxt[3]}, mode_act));
                mode_act <= mode;
            end
        end
endmodule

// File: tb/tb_iq_demux_mqam.sv
// tb_iq_demux_mqam: randomized symbol stream against a bit/symbol-level reference model
module tb_iq_demux_mqam;
    localparam int DIV = 4;
    localparam int OSR = 5;

    logic clk = 1'b0, rst_n, en, sync_clr, mode, ser_i;
    logic signed [3:0] i_out, q_out;
    logic sym_valid, mode_act;
    logic [3:0] ei, eq, ni, nq;
    logic ema;
    int n_chk = 0, n_fail = 0;

    iq_demux_mqam #(.DIV_MAX(DIV), .OSR(OSR), .OUT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .sync_clr  (sync_clr),
        .mode      (mode),
        .ser_i     (ser_i),
        .I         (i_out),
        .Q         (q_out),
        .sym_valid (sym_valid),
        .mode_act  (mode_act)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] lvl(input logic m, input logic msb, input logic lsb);
        int gray[4];
        gray = '{-3, -1, 3, 1};
        if (!m) return msb ? 4'd1 : 4'hF;
        return 4'(gray[{msb, lsb}]);
    endfunction

    task automatic check_all(input logic exp_v);
        check("sym_valid", {31'b0, sym_valid}, {31'b0, exp_v});
        check("I", {28'b0, $unsigned(i_out)}, {28'b0, ei});
        check("Q", {28'b0, $unsigned(q_out)}, {28'b0, eq});
        check("mode_act", {31'b0, mode_act}, {31'b0, ema});
    endtask

    task automatic drive(input logic e, input logic s, input logic sc, input logic last);
        en = e;
        ser_i = s;
        sync_clr = sc;
        @(posedge clk);
        #1;
        sync_clr = 1'b0;
        if (last) begin
            ei = ni;
            eq = nq;
            ema = mode;
        end
        if (sc) ema = mode;
        check_all(last);
    endtask

    // one symbol in the current mode_act; mode input flips to nm halfway through
    task automatic run_symbol(input logic nm, input logic [3:0] fb, input bit forced,
                              input bit gap13, input int abort_at, input bit abort_rst);
        logic m;
        logic [3:0] bits;
        logic [OSR-1:0] pat;
        int nb, n, mid;
        logic last;
        m = ema;
        nb = m ? 4 : 2;
        n = 0;
        mid = nb * OSR * DIV / 2;
        bits = '0;
        for (int b = 0; b < nb; b++) begin
            pat = forced ? (fb[b] ? 5'b10101 : 5'b01001) : OSR'($urandom);
            bits[b] = ($countones(pat) * 2 > OSR);
            for (int s = 0; s < OSR; s++)
                for (int c = 0; c < DIV; c++) begin
                    if (gap13 && b == 0 && s == 2 && c == 1)
                        repeat (13) drive(1'b0, 1'($urandom), 1'b0, 1'b0);
                    while (!forced && $urandom_range(0, 11) == 0)
                        drive(1'b0, 1'($urandom), 1'b0, 1'b0);
                    mode = n < mid ? !nm : nm;
                    if (n == abort_at) begin
                        if (abort_rst) begin
                            rst_n = 1'b0;
                            #2;
                            ei = 4'hF;
                            eq = 4'hF;
                            ema = 1'b0;
                            check_all(1'b0);
                            @(posedge clk);
                            #1;
                            rst_n = 1'b1;
                        end else
                            drive(1'($urandom), 1'($urandom), 1'b1, 1'b0);
                        return;
                    end
                    last = (b == nb - 1) && (s == OSR - 1) && (c == DIV - 1);
                    if (last) begin
                        nq = lvl(m, bits[0], bits[2]);
                        ni = lvl(m, bits[1], bits[3]);
                    end
                    drive(1'b1, c == DIV - 1 ? pat[s] : 1'($urandom), 1'b0, last);
                    n++;
                end
        end
    endtask

    initial begin
        int r, ab;
        bit rs;
        rst_n = 1'b0;
        en = 1'b0;
        sync_clr = 1'b0;
        mode = 1'b0;
        ser_i = 1'b0;
        ei = 4'hF;
        eq = 4'hF;
        ema = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all(1'b0);
        rst_n = 1'b1;
        run_symbol(1'b0, 4'b0001, 1, 0, -1, 0);
        run_symbol(1'b1, 4'b0010, 1, 0, -1, 0);
        run_symbol(1'b1, 4'b0001, 1, 0, -1, 0);
        run_symbol(1'b0, 4'b1110, 1, 0, -1, 0);
        run_symbol(1'b0, 4'b0000, 0, 1, -1, 0);
        run_symbol(1'b1, 4'b0000, 0, 0, 30, 0);
        run_symbol(1'b0, 4'b0000, 0, 0, -1, 0);
        run_symbol(1'b1, 4'b0000, 0, 0, 25, 1);
        run_symbol(1'b1, 4'b0000, 0, 0, -1, 0);
        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 9);
            ab = -1;
            rs = 0;
            if (r < 2) begin
                ab = $urandom_range(0, (ema ? 80 : 40) - 1);
                rs = (r == 1);
            end
            run_symbol(1'($urandom), 4'($urandom), 0, 0, ab, rs);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
